game_timer: RTL and testbench

//  Elapsed-time stopwatch for the game top level. Counts HH:MM:SS from reset.

---
 rtl/timer_pkg.sv | 19 +
 rtl/seg7_dec.sv | 25 ++
 rtl/game_timer.sv | 87 ++++++++
 tb/tb_game_timer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared BCD/7-segment types and active-low gfedcba digit codes
package timer_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - combinational BCD to active-low 7-segment decoder
module seg7_dec
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - HH:MM:SS stopwatch with prescaler, BCD cascade and six 7-seg outputs
module game_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int HR_MAX = 23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       switch,
  input  logic       finish,
  output logic [6:0] hr1,
  output logic [6:0] hr0,
  output logic [6:0] min1,
  output logic [6:0] min0,
  output logic [6:0] sec1,
  output logic [6:0] sec0
);

  // A one-count prescaler still needs a 1-bit register that simply stays at zero.
  localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam bcd_t             HR_TENS  = bcd_t'(HR_MAX / 10);
  localparam bcd_t             HR_UNITS = bcd_t'(HR_MAX % 10);

  logic [PRE_W-1:0] pre;
  bcd_t             s0, s1, m0, m1, h0, h1;
  logic             run, tick, c_s0, c_s1, c_m0, c_hr;

  assign run  = switch & ~finish;
  assign tick = run & (pre == PRE_LAST);
  assign c_s0 = tick & (s0 == 4'd9);
  assign c_s1 = c_s0 & (s1 == 4'd5);
  assign c_m0 = c_s1 & (m0 == 4'd9);
  assign c_hr = c_m0 & (m1 == 4'd5);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   pre <= '0;
    else if (run) pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    s0 <= '0;
    else if (tick) s0 <= (s0 == 4'd9) ? 4'd0 : s0 + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    s1 <= '0;
    else if (c_s0) s1 <= (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    m0 <= '0;
    else if (c_s1) m0 <= (m0 == 4'd9) ? 4'd0 : m0 + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    m1 <= '0;
    else if (c_m0) m1 <= (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
  end

  // Hour wrap is checked before the BCD units carry so HR_MAX may end in any digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h0 <= '0;
      h1 <= '0;
    end else if (c_hr) begin
      if (h1 == HR_TENS && h0 == HR_UNITS) begin
        h0 <= '0;
        h1 <= '0;
      end else if (h0 == 4'd9) begin
        h0 <= '0;
        h1 <= h1 + 4'd1;
      end else begin
        h0 <= h0 + 4'd1;
      end
    end
  end

  seg7_dec u_hr1  (.digit(h1), .seg(hr1));
  seg7_dec u_hr0  (.digit(h0), .seg(hr0));
  seg7_dec u_min1 (.digit(m1), .seg(min1));
  seg7_dec u_min0 (.digit(m0), .seg(min0));
  seg7_dec u_sec1 (.digit(s1), .seg(sec1));
  seg7_dec u_sec0 (.digit(s0), .seg(sec0));

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - randomized bench for game_timer against an elapsed-seconds model
module tb_game_timer;

  localparam int CLK_HZ_A = 4;
  localparam int HR_MAX_A = 23;
  localparam int CLK_HZ_B = 1;
  localparam int HR_MAX_B = 13;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a = 1'b0, switch_a = 1'b0, finish_a = 1'b0;
  logic reset_b = 1'b0, switch_b = 1'b0, finish_b = 1'b0;
  logic [6:0] hr1_a, hr0_a, min1_a, min0_a, sec1_a, sec0_a;
  logic [6:0] hr1_b, hr0_b, min1_b, min0_b, sec1_b, sec0_b;

  game_timer #(.CLK_HZ(CLK_HZ_A), .HR_MAX(HR_MAX_A)) dut_a (
    .clock(clock), .reset(reset_a), .switch(switch_a), .finish(finish_a),
    .hr1(hr1_a), .hr0(hr0_a), .min1(min1_a), .min0(min0_a), .sec1(sec1_a), .sec0(sec0_a)
  );

  game_timer #(.CLK_HZ(CLK_HZ_B), .HR_MAX(HR_MAX_B)) dut_b (
    .clock(clock), .reset(reset_b), .switch(switch_b), .finish(finish_b),
    .hr1(hr1_b), .hr0(hr0_b), .min1(min1_b), .min0(min0_b), .sec1(sec1_b), .sec0(sec0_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: total elapsed seconds plus running clocks into the current second.
  int secs_a = 0, cyc_a = 0;
  int secs_b = 0, cyc_b = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_time(input string tag, input int secs,
                            input logic [6:0] h1, input logic [6:0] h0,
                            input logic [6:0] n1, input logic [6:0] n0,
                            input logic [6:0] c1, input logic [6:0] c0);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    check({tag, ".hr1"},  h1, seg_tab[h / 10]);
    check({tag, ".hr0"},  h0, seg_tab[h % 10]);
    check({tag, ".min1"}, n1, seg_tab[m / 10]);
    check({tag, ".min0"}, n0, seg_tab[m % 10]);
    check({tag, ".sec1"}, c1, seg_tab[s / 10]);
    check({tag, ".sec0"}, c0, seg_tab[s % 10]);
  endtask

  task automatic check_all(input string tag);
    check_time({tag, ".a"}, secs_a, hr1_a, hr0_a, min1_a, min0_a, sec1_a, sec0_a);
    check_time({tag, ".b"}, secs_b, hr1_b, hr0_b, min1_b, min0_b, sec1_b, sec0_b);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, ".hr1"},  hr1_a,  7'h40);
    check({tag, ".hr0"},  hr0_a,  7'h40);
    check({tag, ".min1"}, min1_a, 7'h40);
    check({tag, ".min0"}, min0_a, 7'h40);
    check({tag, ".sec1"}, sec1_a, 7'h40);
    check({tag, ".sec0"}, sec0_a, 7'h40);
  endtask

  task automatic step(input string tag, input logic sw_a, input logic fin_a,
                      input logic sw_b, input logic fin_b);
    switch_a = sw_a;
    finish_a = fin_a;
    switch_b = sw_b;
    finish_b = fin_b;
    @(posedge clock);
    if (reset_a && sw_a && !fin_a) begin
      cyc_a++;
      if (cyc_a == CLK_HZ_A) begin
        cyc_a  = 0;
        secs_a = (secs_a + 1) % ((HR_MAX_A + 1) * 3600);
      end
    end
    if (reset_b && sw_b && !fin_b) begin
      cyc_b++;
      if (cyc_b == CLK_HZ_B) begin
        cyc_b  = 0;
        secs_b = (secs_b + 1) % ((HR_MAX_B + 1) * 3600);
      end
    end
    #1;
    check_all(tag);
  endtask

  // Asserts reset between edges, holds it across `hold` clock edges of random inputs, releases between edges.
  task automatic pulse_reset(input bit on_a, input bit on_b, input int hold);
    #2;
    if (on_a) begin reset_a = 1'b0; secs_a = 0; cyc_a = 0; end
    if (on_b) begin reset_b = 1'b0; secs_b = 0; cyc_b = 0; end
    #1;
    check_all("rst_async");
    if (on_a) check_zero_a("rst_async_const");
    for (int i = 0; i < hold; i++)
      step("rst_hold", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #2;
    if (on_a) reset_a = 1'b1;
    if (on_b) reset_b = 1'b1;
  endtask

  initial begin
    #3;
    check_all("por");
    check_zero_a("por_const");

    // Reset with arbitrary inputs, then idle for 100 clocks.
    pulse_reset(1'b1, 1'b1, 5);
    for (int i = 0; i < 100; i++) step("idle", 1'b0, 1'($urandom), 1'b0, 1'($urandom));
    check_zero_a("idle_const");

    // First second and first ten seconds.
    for (int i = 0; i < 4; i++) step("run4", 1'b1, 1'b0, 1'b0, 1'b0);
    check("sec0_after_4", sec0_a, 7'h79);
    for (int i = 0; i < 36; i++) step("run40", 1'b1, 1'b0, 1'b0, 1'b0);
    check("sec1_after_40", sec1_a, 7'h79);
    check("sec0_after_40", sec0_a, 7'h40);

    // One minute with two paused clocks inserted.
    pulse_reset(1'b1, 1'b0, 0);
    for (int i = 0; i < 241; i++)
      step("minute", (i != 100 && i != 101), 1'b0, 1'b0, 1'b0);
    check("min0_not_yet", min0_a, 7'h40);
    step("minute", 1'b1, 1'b0, 1'b0, 1'b0);
    check("min0_at_60s", min0_a, 7'h79);
    check("sec1_at_60s", sec1_a, 7'h40);
    check("sec0_at_60s", sec0_a, 7'h40);

    // Freeze mid-second; the held partial second completes after resuming.
    for (int i = 0; i < 2; i++) step("partial", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step("frozen", 1'b1, 1'b1, 1'b0, 1'b0);
    check("frozen_sec0", sec0_a, 7'h40);
    step("resume", 1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_sec0_hold", sec0_a, 7'h40);
    step("resume", 1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_sec0_tick", sec0_a, 7'h79);

    // Randomized run/pause/freeze with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 199) == 0) pulse_reset(1'b1, 1'b0, $urandom_range(0, 2));
    end

    // Reset in the middle of a second discards the partial count.
    pulse_reset(1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_reset(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_sec0_hold", sec0_a, 7'h40);
    step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_sec0_tick", sec0_a, 7'h79);

    // Full-day wrap on the one-clock-per-second instance, through 09->10 hours.
    pulse_reset(1'b0, 1'b1, 0);
    for (int i = 0; i < (HR_MAX_B + 1) * 3600 - 1; i++) step("day", 1'b0, 1'b0, 1'b1, 1'b0);
    check("day_end_hr1", hr1_b, 7'h79);
    check("day_end_hr0", hr0_b, 7'h30);
    check("day_end_sec0", sec0_b, 7'h10);
    step("wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_hr1", hr1_b, 7'h40);
    check("wrap_hr0", hr0_b, 7'h40);
    check("wrap_min1", min1_b, 7'h40);
    check("wrap_min0", min0_b, 7'h40);
    check("wrap_sec1", sec1_b, 7'h40);
    check("wrap_sec0", sec0_b, 7'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
